// File: rtl/pin_bus_bridge.sv
// pin_bus_bridge: multiplexed address/data pin bridge with read turnaround and wait states.
// Optional feature macro BUS_TIMEOUT_EN bounds DATA-phase waits to TIMEOUT_CYC and raises cpu_err.
module pin_bus_bridge #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 4,
  parameter int PIN_W       = 8,
  parameter int TURN_CYC    = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              busy,
  output logic [PIN_W-1:0]  pin_addr,
  output logic              pin_ale,
  output logic              pin_rw,
  output logic [DATA_W-1:0] pin_data_out,
  output logic [DATA_W-1:0] pin_data_oe,
  input  logic [DATA_W-1:0] pin_data_in,
  input  logic              pin_wait
);

  localparam int unsigned NB     = (ADDR_W + PIN_W - 1) / PIN_W;
  localparam int unsigned EXT_W  = NB * PIN_W;
  localparam int unsigned BEAT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  if (ADDR_W < 1 || DATA_W < 1 || PIN_W < 1 || TURN_CYC < 0 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("pin_bus_bridge: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    TURN,
    DATA,
    DONE
  } state_t;

  state_t              state;
  logic                we_q;
  logic [EXT_W-1:0]    addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [TURN_W-1:0]   turn_cnt;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WAIT_W-1:0]   wait_cnt;
`endif

  // Beat 0 is the most-significant PIN_W slice of the zero-extended address.
  function automatic logic [PIN_W-1:0] beat_slice(input logic [EXT_W-1:0] ext,
                                                  input int unsigned beat);
    logic [EXT_W-1:0] sh;
    sh = ext >> ((NB - 1 - beat) * PIN_W);
    return sh[PIN_W-1:0];
  endfunction

  // Outputs are assigned together with the state they belong to, so every pin is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_cnt     <= '0;
      turn_cnt     <= '0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      busy         <= 1'b0;
      pin_addr     <= '0;
      pin_ale      <= 1'b0;
      pin_rw       <= 1'b0;
      pin_data_out <= '0;
      pin_data_oe  <= '0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt     <= '0;
      cpu_err      <= 1'b0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            we_q     <= cpu_we;
            addr_q   <= EXT_W'(cpu_addr);
            wdata_q  <= cpu_wdata;
            beat_cnt <= '0;
            state    <= ADDR;
            busy     <= 1'b1;
            pin_ale  <= 1'b1;
            pin_addr <= beat_slice(EXT_W'(cpu_addr), 32'd0);
            pin_rw   <= cpu_we;
`ifdef BUS_TIMEOUT_EN
            cpu_err  <= 1'b0;
`endif
          end
        end

        ADDR: begin
          if (beat_cnt == BEAT_W'(NB - 1)) begin
            pin_ale  <= 1'b0;
            pin_addr <= '0;
            if (we_q || TURN_CYC == 0) begin
              state        <= DATA;
              pin_data_oe  <= {DATA_W{we_q}};
              pin_data_out <= we_q ? wdata_q : '0;
`ifdef BUS_TIMEOUT_EN
              wait_cnt     <= '0;
`endif
            end else begin
              state    <= TURN;
              turn_cnt <= '0;
            end
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            pin_addr <= beat_slice(addr_q, 32'(beat_cnt) + 32'd1);
          end
        end

        TURN: begin
          if (turn_cnt == TURN_W'(TURN_CYC - 1)) begin
            state        <= DATA;
            pin_data_oe  <= '0;
            pin_data_out <= '0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end

        DATA: begin
          if (!pin_wait) begin
            if (!we_q) cpu_rdata <= pin_data_in;
            state        <= DONE;
            cpu_ready    <= 1'b1;
            pin_rw       <= 1'b0;
            pin_data_oe  <= '0;
            pin_data_out <= '0;
          end
`ifdef BUS_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
            state        <= DONE;
            cpu_ready    <= 1'b1;
            cpu_err      <= 1'b1;
            pin_rw       <= 1'b0;
            pin_data_oe  <= '0;
            pin_data_out <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef BUS_TIMEOUT_EN
  assign cpu_err = 1'b0;
`endif

endmodule

// File: tb/tb_pin_bus_bridge.sv
// tb_pin_bus_bridge: directed transfers checked every cycle against a transaction-level model.
// The model expands each transfer into its expected per-cycle pin/handshake trace.
module tb_pin_bus_bridge;

  localparam int A_W    = 12;
  localparam int D_W    = 4;
  localparam int P_W    = 8;
  localparam int T_CYC  = 1;
  localparam int TO_CYC = 16;
  localparam int NBEAT  = (A_W + P_W - 1) / P_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cpu_req = 1'b0;
  logic           cpu_we = 1'b0;
  logic [A_W-1:0] cpu_addr = '0;
  logic [D_W-1:0] cpu_wdata = '0;
  logic           cpu_ready;
  logic [D_W-1:0] cpu_rdata;
  logic           cpu_err;
  logic           busy;
  logic [P_W-1:0] pin_addr;
  logic           pin_ale;
  logic           pin_rw;
  logic [D_W-1:0] pin_data_out;
  logic [D_W-1:0] pin_data_oe;
  logic [D_W-1:0] pin_data_in = '0;
  logic           pin_wait = 1'b0;

  pin_bus_bridge #(
    .ADDR_W(A_W), .DATA_W(D_W), .PIN_W(P_W), .TURN_CYC(T_CYC), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .busy(busy), .pin_addr(pin_addr), .pin_ale(pin_ale), .pin_rw(pin_rw),
    .pin_data_out(pin_data_out), .pin_data_oe(pin_data_oe), .pin_data_in(pin_data_in),
    .pin_wait(pin_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           busy, ready, err, ale, rw;
    logic [P_W-1:0] addr;
    logic [D_W-1:0] oe, dout, rdata;
  } obs_t;

  obs_t           exp_q[$];
  logic [D_W-1:0] m_rdata = '0;
  int             tests = 0;
  int             fails = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address beat b: PIN_W-wide digit of the address, most significant digit first.
  function automatic logic [P_W-1:0] beat_slice(input longint unsigned a, input int b);
    longint unsigned unit, base;
    unit = longint'(1) << P_W;
    base = 1;
    for (int i = 0; i < NBEAT - 1 - b; i++) base = base * unit;
    return P_W'((a / base) % unit);
  endfunction

  function automatic obs_t idle_obs(input logic [D_W-1:0] rd, input logic er);
    obs_t o;
    o = '{busy:1'b0, ready:1'b0, err:er, ale:1'b0, rw:1'b0, addr:'0, oe:'0, dout:'0, rdata:rd};
    return o;
  endfunction

  // Per-cycle compare: pops one expected cycle per clock, idle expectations otherwise.
  initial begin
    obs_t           e;
    logic [D_W-1:0] last_rd;
    logic           last_err;
    bit             r;
    last_rd  = '0;
    last_err = 1'b0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        exp_q.delete();
        last_rd  = '0;
        last_err = 1'b0;
        e = idle_obs(last_rd, last_err);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_rd  = e.rdata;
        last_err = e.err;
      end else begin
        e = idle_obs(last_rd, last_err);
      end
      chk("busy",         busy,         e.busy);
      chk("cpu_ready",    cpu_ready,    e.ready);
      chk("cpu_err",      cpu_err,      e.err);
      chk("cpu_rdata",    cpu_rdata,    e.rdata);
      chk("pin_ale",      pin_ale,      e.ale);
      chk("pin_rw",       pin_rw,       e.rw);
      chk("pin_addr",     pin_addr,     e.addr);
      chk("pin_data_oe",  pin_data_oe,  e.oe);
      chk("pin_data_out", pin_data_out, e.dout);
    end
  end

  // One transfer starting at a negedge in IDLE; returns at the negedge of the following idle cycle.
  task automatic do_xfer(input string name, input bit we, input logic [A_W-1:0] addr,
                         input logic [D_W-1:0] wd, input logic [D_W-1:0] rin, input int nwait,
                         input bit hold, input logic [P_W-1:0] lit_b0, input logic [P_W-1:0] lit_b1,
                         input int lit_ready, input logic [D_W-1:0] lit_rdata, input logic lit_err);
    obs_t e;
    bit   tmo = 1'b0;
    int   nturn = we ? 0 : T_CYC;
    int   kd, ndata, nw, n;
    int   ready_at = 0;
    int   nready = 0;
`ifdef BUS_TIMEOUT_EN
    tmo = (nwait >= TO_CYC);
`endif
    kd    = NBEAT + nturn + 1;
    ndata = tmo ? TO_CYC : nwait + 1;
    nw    = tmo ? TO_CYC : nwait;
    n     = kd + ndata;
    for (int c = 1; c <= n; c++) begin
      e = '{busy:1'b1, ready:1'b0, err:1'b0, ale:1'b0, rw:we, addr:'0, oe:'0, dout:'0, rdata:m_rdata};
      if (c <= NBEAT) begin
        e.ale  = 1'b1;
        e.addr = beat_slice(addr, c - 1);
      end else if (c >= kd && c < n) begin
        e.oe   = we ? '1 : '0;
        e.dout = we ? wd : '0;
      end else if (c == n) begin
        e.ready = 1'b1;
        e.rw    = 1'b0;
        e.err   = tmo;
        if (!we && !tmo) m_rdata = rin;
        e.rdata = m_rdata;
      end
      exp_q.push_back(e);
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (!hold) cpu_req = 1'b0;
      pin_wait    = (c >= kd && c < kd + nw);
      pin_data_in = pin_wait ? ~rin : rin;
      if (c == 1) chk({name, " beat0"}, pin_addr, lit_b0);
      if (c == 2) chk({name, " beat1"}, pin_addr, lit_b1);
      if (cpu_ready) begin
        ready_at = c;
        nready++;
        chk({name, " rdata"}, cpu_rdata, lit_rdata);
        chk({name, " err"}, cpu_err, lit_err);
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; pin_wait = 1'b0; pin_data_in = '0;
    chk({name, " ready cycle"}, ready_at, lit_ready);
    chk({name, " ready pulses"}, nready, 1);
  endtask

  task automatic reset_mid(input logic [A_W-1:0] addr);
    obs_t e;
    int   nready = 0;
    for (int c = 1; c <= 2; c++) begin
      e = '{busy:1'b1, ready:1'b0, err:1'b0, ale:1'b1, rw:1'b1, addr:beat_slice(addr, c - 1),
            oe:'0, dout:'0, rdata:m_rdata};
      exp_q.push_back(e);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = 4'h7;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid busy", busy, 0);
    chk("rstmid ale", pin_ale, 0);
    chk("rstmid addr", pin_addr, 0);
    for (int c = 0; c < 3; c++) begin
      if (cpu_ready) nready++;
      @(negedge clk);
    end
    chk("rstmid no ready", nready, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_xfer("wr_a5c", 1'b1, 12'hA5C, 4'h9, 4'h0, 0, 1'b0, 8'h0A, 8'h5C, 4, 4'h0, 1'b0);
    do_xfer("rd_123", 1'b0, 12'h123, 4'h0, 4'h6, 0, 1'b0, 8'h01, 8'h23, 5, 4'h6, 1'b0);
    do_xfer("rd_wait3", 1'b0, 12'h3C7, 4'h0, 4'hA, 3, 1'b0, 8'h03, 8'hC7, 8, 4'hA, 1'b0);
    do_xfer("hold_wr", 1'b1, 12'h0FF, 4'h5, 4'h0, 0, 1'b1, 8'h00, 8'hFF, 4, 4'hA, 1'b0);
    do_xfer("hold_rd", 1'b0, 12'h800, 4'h0, 4'h3, 0, 1'b1, 8'h08, 8'h00, 5, 4'h3, 1'b0);
    reset_mid(12'h456);
    do_xfer("rd_fresh", 1'b0, 12'h7E1, 4'h0, 4'hC, 0, 1'b0, 8'h07, 8'hE1, 5, 4'hC, 1'b0);
    do_xfer("wr_wait2", 1'b1, 12'h999, 4'h1, 4'h0, 2, 1'b0, 8'h09, 8'h99, 6, 4'hC, 1'b0);
`ifdef BUS_TIMEOUT_EN
    do_xfer("rd_tmo", 1'b0, 12'h0AB, 4'h0, 4'h5, 1000, 1'b0, 8'h00, 8'hAB, 20, 4'hC, 1'b1);
    repeat (2) @(negedge clk);
    chk("err held idle", cpu_err, 1);
    do_xfer("wr_clr", 1'b1, 12'h0AB, 4'h2, 4'h0, 0, 1'b0, 8'h00, 8'hAB, 4, 4'hC, 1'b0);
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
